// File: rtl/reorder_buffer.sv
// Reorder buffer: takes up to two dispatches per cycle into dispatcher-chosen entries and
// retires up to two completed entries per cycle in program order. Optional flush: ROB_FLUSH_EN.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int PREGS = 64,
  parameter int PC_W  = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             disp_valid1,
  input  logic             disp_valid2,
  input  logic [IDX_W-1:0] disp_rob_num1,
  input  logic [IDX_W-1:0] disp_rob_num2,
  input  logic [4:0]       disp_dest_reg1,
  input  logic [4:0]       disp_dest_reg2,
  input  logic [5:0]       disp_dest_old1,
  input  logic [5:0]       disp_dest_old2,
  input  logic [PC_W-1:0]  disp_pc1,
  input  logic [PC_W-1:0]  disp_pc2,
  input  logic             cmpl_valid1,
  input  logic             cmpl_valid2,
  input  logic [IDX_W-1:0] cmpl_rob_num1,
  input  logic [IDX_W-1:0] cmpl_rob_num2,
  output logic [DEPTH-1:0] rob_free,
  output logic [4:0]       rob_count,
  output logic             retire_valid1,
  output logic             retire_valid2,
  output logic [4:0]       retire_dest_reg1,
  output logic [4:0]       retire_dest_reg2,
  output logic [5:0]       retire_dest_old1,
  output logic [5:0]       retire_dest_old2,
  output logic [PC_W-1:0]  retire_pc1,
  output logic [PC_W-1:0]  retire_pc2,
  output logic [PREGS-1:0] retire_reg_ready,
  output logic             err_sticky
);

  typedef struct packed {
    logic [4:0]      rd;
    logic [5:0]      old;
    logic [PC_W-1:0] pc;
  } robEntry_t;

  robEntry_t [DEPTH-1:0]       ent;
  logic [DEPTH-1:0]            busy, done, busyNxt, doneNxt;
  logic [DEPTH-1:0][IDX_W-1:0] orderQ;
  logic [IDX_W:0]              head, tail;
  logic [IDX_W-1:0]            h0, h1;
  logic                        flushNow, acc1, acc2, ret0, ret1, dispErr;
  logic [PREGS-1:0]            regReadyNxt;

`ifdef ROB_FLUSH_EN
  assign flushNow = flush;
`else
  assign flushNow = 1'b0;
`endif

  // Pointers carry one extra bit so full and empty differ; DEPTH is a power of two.
  assign h0 = orderQ[head[IDX_W-1:0]];
  assign h1 = orderQ[head[IDX_W-1:0] + IDX_W'(1)];

  assign acc1 = ~flushNow & disp_valid1 & ~busy[disp_rob_num1];
  assign acc2 = ~flushNow & disp_valid2 & ~busy[disp_rob_num2]
              & ~(acc1 & (disp_rob_num2 == disp_rob_num1));
  assign dispErr = ~flushNow & ((disp_valid1 & ~acc1) | (disp_valid2 & ~acc2));

  assign ret0 = ~flushNow & (head != tail) & busy[h0] & done[h0];
  assign ret1 = ret0 & (rob_count >= 5'd2) & busy[h1] & done[h1];

  assign rob_free = ~busy;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic cmplHit, retHit, dispHit;
    assign cmplHit = (cmpl_valid1 & (cmpl_rob_num1 == IDX_W'(e)))
                   | (cmpl_valid2 & (cmpl_rob_num2 == IDX_W'(e)));
    assign retHit  = (ret0 & (h0 == IDX_W'(e))) | (ret1 & (h1 == IDX_W'(e)));
    assign dispHit = (acc1 & (disp_rob_num1 == IDX_W'(e)))
                   | (acc2 & (disp_rob_num2 == IDX_W'(e)));
    // Dispatch needs a free entry and retire a busy one, so they never collide.
    assign busyNxt[e] = dispHit | (busy[e] & ~retHit);
    assign doneNxt[e] = ~dispHit & ~retHit & (done[e] | (cmplHit & busy[e]));
  end

  always_comb begin
    regReadyNxt = '0;
    if (ret0 && ent[h0].rd != 5'd0) regReadyNxt[ent[h0].old] = 1'b1;
    if (ret1 && ent[h1].rd != 5'd0) regReadyNxt[ent[h1].old] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= '0;
      done       <= '0;
      head       <= '0;
      tail       <= '0;
      rob_count  <= '0;
      err_sticky <= 1'b0;
    end else if (flushNow) begin
      busy      <= '0;
      done      <= '0;
      head      <= tail;
      rob_count <= '0;
    end else begin
      busy      <= busyNxt;
      done      <= doneNxt;
      head      <= head + (IDX_W+1)'(ret0) + (IDX_W+1)'(ret1);
      tail      <= tail + (IDX_W+1)'(acc1) + (IDX_W+1)'(acc2);
      rob_count <= rob_count + 5'(acc1) + 5'(acc2) - 5'(ret0) - 5'(ret1);
      if (dispErr) err_sticky <= 1'b1;
    end
  end

  // Payload and order queue need no reset; busy qualifies them.
  always_ff @(posedge clk) begin
    if (acc1) begin
      ent[disp_rob_num1]          <= '{rd: disp_dest_reg1, old: disp_dest_old1, pc: disp_pc1};
      orderQ[tail[IDX_W-1:0]]     <= disp_rob_num1;
    end
    if (acc2) begin
      ent[disp_rob_num2]          <= '{rd: disp_dest_reg2, old: disp_dest_old2, pc: disp_pc2};
      orderQ[tail[IDX_W-1:0] + IDX_W'(acc1)] <= disp_rob_num2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_valid1    <= 1'b0;
      retire_valid2    <= 1'b0;
      retire_dest_reg1 <= '0;
      retire_dest_reg2 <= '0;
      retire_dest_old1 <= '0;
      retire_dest_old2 <= '0;
      retire_pc1       <= '0;
      retire_pc2       <= '0;
      retire_reg_ready <= '0;
    end else begin
      retire_valid1    <= ret0;
      retire_valid2    <= ret1;
      retire_reg_ready <= regReadyNxt;
      if (ret0) begin
        retire_dest_reg1 <= ent[h0].rd;
        retire_dest_old1 <= ent[h0].old;
        retire_pc1       <= ent[h0].pc;
      end
      if (ret1) begin
        retire_dest_reg2 <= ent[h1].rd;
        retire_dest_old2 <= ent[h1].old;
        retire_pc2       <= ent[h1].pc;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized bench for reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int PREGS = 64;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif
  logic             disp_valid1 = 0, disp_valid2 = 0;
  logic [IDX_W-1:0] disp_rob_num1 = 0, disp_rob_num2 = 0;
  logic [4:0]       disp_dest_reg1 = 0, disp_dest_reg2 = 0;
  logic [5:0]       disp_dest_old1 = 0, disp_dest_old2 = 0;
  logic [PC_W-1:0]  disp_pc1 = 0, disp_pc2 = 0;
  logic             cmpl_valid1 = 0, cmpl_valid2 = 0;
  logic [IDX_W-1:0] cmpl_rob_num1 = 0, cmpl_rob_num2 = 0;
  logic [DEPTH-1:0] rob_free;
  logic [4:0]       rob_count;
  logic             retire_valid1, retire_valid2;
  logic [4:0]       retire_dest_reg1, retire_dest_reg2;
  logic [5:0]       retire_dest_old1, retire_dest_old2;
  logic [PC_W-1:0]  retire_pc1, retire_pc2;
  logic [PREGS-1:0] retire_reg_ready;
  logic             err_sticky;

  reorder_buffer #(.DEPTH(DEPTH), .PREGS(PREGS), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .disp_valid1(disp_valid1), .disp_valid2(disp_valid2),
    .disp_rob_num1(disp_rob_num1), .disp_rob_num2(disp_rob_num2),
    .disp_dest_reg1(disp_dest_reg1), .disp_dest_reg2(disp_dest_reg2),
    .disp_dest_old1(disp_dest_old1), .disp_dest_old2(disp_dest_old2),
    .disp_pc1(disp_pc1), .disp_pc2(disp_pc2),
    .cmpl_valid1(cmpl_valid1), .cmpl_valid2(cmpl_valid2),
    .cmpl_rob_num1(cmpl_rob_num1), .cmpl_rob_num2(cmpl_rob_num2),
    .rob_free(rob_free), .rob_count(rob_count),
    .retire_valid1(retire_valid1), .retire_valid2(retire_valid2),
    .retire_dest_reg1(retire_dest_reg1), .retire_dest_reg2(retire_dest_reg2),
    .retire_dest_old1(retire_dest_old1), .retire_dest_old2(retire_dest_old2),
    .retire_pc1(retire_pc1), .retire_pc2(retire_pc2),
    .retire_reg_ready(retire_reg_ready), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: entry table plus a program-order queue of entry numbers.
  bit              mBusy[DEPTH];
  bit              mDone[DEPTH];
  logic [4:0]      mRd[DEPTH];
  logic [5:0]      mOld[DEPTH];
  logic [PC_W-1:0] mPc[DEPTH];
  int              q[$];
  bit              mErr;
  bit              eV1, eV2;
  logic [4:0]      eRd1, eRd2;
  logic [5:0]      eOld1, eOld2;
  logic [PC_W-1:0] ePc1, ePc2;
  logic [PREGS-1:0] eRr;

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mBusy[i] = 0; mDone[i] = 0; mRd[i] = 0; mOld[i] = 0; mPc[i] = 0;
    end
    q.delete();
    mErr = 0; eV1 = 0; eV2 = 0; eRr = '0;
    eRd1 = 0; eRd2 = 0; eOld1 = 0; eOld2 = 0; ePc1 = 0; ePc2 = 0;
  endtask

  function automatic logic [DEPTH-1:0] freeMask();
    logic [DEPTH-1:0] m;
    for (int i = 0; i < DEPTH; i++) m[i] = !mBusy[i];
    return m;
  endfunction

  function automatic int pickFree(input int excl);
    int c[$];
    for (int i = 0; i < DEPTH; i++) if (!mBusy[i] && i != excl) c.push_back(i);
    if (c.size() == 0) return int'($urandom_range(DEPTH-1));
    return c[$urandom_range(c.size()-1)];
  endfunction

  function automatic int pickBusy();
    int c[$];
    for (int i = 0; i < DEPTH; i++) if (mBusy[i]) c.push_back(i);
    if (c.size() == 0) return int'($urandom_range(DEPTH-1));
    return c[$urandom_range(c.size()-1)];
  endfunction

  task automatic clearIn();
    disp_valid1 = 0; disp_valid2 = 0; cmpl_valid1 = 0; cmpl_valid2 = 0;
`ifdef ROB_FLUSH_EN
    flush = 0;
`endif
  endtask

  task automatic setDisp(input int s, input int n, input int rd, input int old, input int pc);
    if (s == 1) begin
      disp_valid1 = 1; disp_rob_num1 = IDX_W'(n); disp_dest_reg1 = 5'(rd);
      disp_dest_old1 = 6'(old); disp_pc1 = PC_W'(pc);
    end else begin
      disp_valid2 = 1; disp_rob_num2 = IDX_W'(n); disp_dest_reg2 = 5'(rd);
      disp_dest_old2 = 6'(old); disp_pc2 = PC_W'(pc);
    end
  endtask

  task automatic setCmpl(input int s, input int n);
    if (s == 1) begin cmpl_valid1 = 1; cmpl_rob_num1 = IDX_W'(n); end
    else        begin cmpl_valid2 = 1; cmpl_rob_num2 = IDX_W'(n); end
  endtask

  // Advance one clock: predict from pre-edge model state, then compare after the edge.
  task automatic step();
    bit r0, r1, a1, a2, fl;
    int h0, h1;
    fl = 0;
`ifdef ROB_FLUSH_EN
    fl = flush;
`endif
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) begin mBusy[i] = 0; mDone[i] = 0; end
      q.delete();
      eV1 = 0; eV2 = 0; eRr = '0;
    end else begin
      r0 = q.size() > 0 && mBusy[q[0]] && mDone[q[0]];
      r1 = r0 && q.size() >= 2 && mBusy[q[1]] && mDone[q[1]];
      h0 = r0 ? q[0] : 0;
      h1 = r1 ? q[1] : 0;
      a1 = disp_valid1 && !mBusy[disp_rob_num1];
      a2 = disp_valid2 && !mBusy[disp_rob_num2] && !(a1 && disp_rob_num2 == disp_rob_num1);
      eV1 = r0; eV2 = r1; eRr = '0;
      if (r0) begin
        eRd1 = mRd[h0]; eOld1 = mOld[h0]; ePc1 = mPc[h0];
        if (mRd[h0] != 0) eRr[mOld[h0]] = 1'b1;
      end
      if (r1) begin
        eRd2 = mRd[h1]; eOld2 = mOld[h1]; ePc2 = mPc[h1];
        if (mRd[h1] != 0) eRr[mOld[h1]] = 1'b1;
      end
      if (cmpl_valid1 && mBusy[cmpl_rob_num1]) mDone[cmpl_rob_num1] = 1;
      if (cmpl_valid2 && mBusy[cmpl_rob_num2]) mDone[cmpl_rob_num2] = 1;
      if (r0) begin mBusy[h0] = 0; mDone[h0] = 0; void'(q.pop_front()); end
      if (r1) begin mBusy[h1] = 0; mDone[h1] = 0; void'(q.pop_front()); end
      if (a1) begin
        mBusy[disp_rob_num1] = 1; mDone[disp_rob_num1] = 0; mRd[disp_rob_num1] = disp_dest_reg1;
        mOld[disp_rob_num1] = disp_dest_old1; mPc[disp_rob_num1] = disp_pc1;
        q.push_back(int'(disp_rob_num1));
      end
      if (a2) begin
        mBusy[disp_rob_num2] = 1; mDone[disp_rob_num2] = 0; mRd[disp_rob_num2] = disp_dest_reg2;
        mOld[disp_rob_num2] = disp_dest_old2; mPc[disp_rob_num2] = disp_pc2;
        q.push_back(int'(disp_rob_num2));
      end
      if ((disp_valid1 && !a1) || (disp_valid2 && !a2)) mErr = 1;
    end
    @(posedge clk);
    #1;
    chk("rob_free", rob_free, freeMask());
    chk("rob_count", rob_count, q.size());
    chk("retire_valid1", retire_valid1, eV1);
    chk("retire_valid2", retire_valid2, eV2);
    chk("retire_dest_reg1", retire_dest_reg1, eRd1);
    chk("retire_dest_old1", retire_dest_old1, eOld1);
    chk("retire_pc1", retire_pc1, ePc1);
    chk("retire_dest_reg2", retire_dest_reg2, eRd2);
    chk("retire_dest_old2", retire_dest_old2, eOld2);
    chk("retire_pc2", retire_pc2, ePc2);
    chk("retire_reg_ready", retire_reg_ready, eRr);
    chk("err_sticky", err_sticky, mErr);
  endtask

  task automatic resetDut();
    reset = 1;
    clearIn();
    @(posedge clk);
    #1;
    chk("rst_rob_free", rob_free, 16'hFFFF);
    chk("rst_rob_count", rob_count, 0);
    chk("rst_retire_valid1", retire_valid1, 0);
    chk("rst_retire_valid2", retire_valid2, 0);
    chk("rst_reg_ready", retire_reg_ready, 0);
    chk("rst_err_sticky", err_sticky, 0);
    modelReset();
    reset = 0;
  endtask

  initial begin
    int n1, n2;
    modelReset();
    resetDut();

    // Two entries, older completes last; both retire together.
    setDisp(1, 15, 3, 7, 'h100); step(); clearIn();
    setDisp(1, 14, 4, 9, 'h104); step(); clearIn();
    setCmpl(1, 14); step(); clearIn();
    step();
    setCmpl(1, 15); step(); clearIn();
    step();
    chk("pair_valid1", retire_valid1, 1);
    chk("pair_valid2", retire_valid2, 1);
    chk("pair_pc1", retire_pc1, 'h100);
    chk("pair_pc2", retire_pc2, 'h104);
    chk("pair_reg_ready", retire_reg_ready, 64'h280);
    chk("pair_free", rob_free, 16'hFFFF);
    step();

    // Younger done first must wait for the older; rd 0 frees no register.
    setDisp(1, 2, 1, 20, 'h200); setDisp(2, 3, 0, 21, 'h204); step(); clearIn();
    setCmpl(1, 3); step(); clearIn();
    for (int i = 0; i < 3; i++) begin step(); chk("inorder_hold", retire_valid1, 0); end
    setCmpl(2, 2); step(); clearIn();
    step();
    chk("inorder_both", {retire_valid1, retire_valid2}, 2'b11);
    chk("inorder_rd0", retire_reg_ready, 64'h1 << 20);

    // Fill all entries, then dispatch into busy entry 5.
    for (int i = 0; i < 8; i++) begin
      setDisp(1, 2*i, 2*i+1, 2*i+10, 'h1000 + 8*i);
      setDisp(2, 2*i+1, 2*i+2, 2*i+11, 'h1004 + 8*i);
      step(); clearIn();
    end
    chk("full_free", rob_free, 16'h0000);
    setDisp(1, 5, 9, 33, 'hDEAD); step(); clearIn();
    chk("full_err", err_sticky, 1);
    chk("full_count", rob_count, 16);
    for (int i = 0; i < 8; i++) begin
      setCmpl(1, 2*i); setCmpl(2, 2*i+1); step(); clearIn();
    end
    for (int i = 0; i < 12 && q.size() > 0; i++) step();
    chk("drain_count", rob_count, 0);

    // Duplicate slot-2 entry and rejected slot 1 not blocking slot 2.
    resetDut();
    setDisp(1, 4, 1, 1, 'h40); setDisp(2, 4, 2, 2, 'h44); step(); clearIn();
    chk("dup_err", err_sticky, 1);
    setDisp(1, 4, 1, 1, 'h48); setDisp(2, 6, 3, 3, 'h4C); step(); clearIn();
    chk("rej1_slot2", rob_count, 2);

    // Steady dispatch-2 / retire-2 around the queue.
    resetDut();
    for (int r = 0; r < 22; r++) begin
      int cnt;
      cnt = 0;
      n1 = pickFree(-1); n2 = pickFree(n1);
      setDisp(1, n1, $urandom_range(31), $urandom_range(63), $urandom);
      setDisp(2, n2, $urandom_range(31), $urandom_range(63), $urandom);
      for (int k = 0; k < q.size() && cnt < 2; k++)
        if (!mDone[q[k]]) begin cnt++; setCmpl(cnt, q[k]); end
      step(); clearIn();
      if (r >= 2) chk("steady_count", rob_count, 4);
    end
    resetDut();

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      setDisp(1, 2*i, 1, 40+i, 'h300 + i); setDisp(2, 2*i+1, 2, 50+i, 'h310 + i);
      step(); clearIn();
    end
    setCmpl(1, 0); setCmpl(2, 1); step(); clearIn();
    flush = 1; setCmpl(1, 2); step(); clearIn();
    chk("flush_noret", retire_valid1, 0);
    chk("flush_free", rob_free, 16'hFFFF);
    chk("flush_count", rob_count, 0);
    step();
`endif

    // Random traffic, mostly legal, with one mid-stream reset.
    for (int c = 0; c < 500; c++) begin
      if (c == 250) resetDut();
      if ($urandom_range(3) != 0) begin
        n1 = ($urandom_range(9) != 0) ? pickFree(-1) : int'($urandom_range(DEPTH-1));
        setDisp(1, n1, $urandom_range(31), $urandom_range(63), $urandom);
      end
      if ($urandom_range(2) != 0) begin
        n2 = ($urandom_range(9) != 0) ? pickFree(int'(disp_rob_num1)) : int'($urandom_range(DEPTH-1));
        setDisp(2, n2, $urandom_range(31), $urandom_range(63), $urandom);
      end
      if ($urandom_range(2) != 0) setCmpl(1, ($urandom_range(7) != 0) ? pickBusy() : int'($urandom_range(DEPTH-1)));
      if ($urandom_range(2) != 0) setCmpl(2, pickBusy());
`ifdef ROB_FLUSH_EN
      if ($urandom_range(60) == 0) flush = 1;
`endif
      step(); clearIn();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
